// File: rtl/uart_link_responder_if.sv
// UART-side byte interface of uart_link_responder.
// Carries the receiver byte and error levels in, and the transmitter write strobe and byte out.
interface uart_link_responder_if;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       TX_BUSY;
    logic [7:0] Tx_DATA;
    logic       Tx_WR;

    modport master (
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, TX_BUSY,
        input  Tx_DATA, Tx_WR
    );

    modport slave (
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, TX_BUSY,
        output Tx_DATA, Tx_WR
    );
endinterface

// File: rtl/uart_link_responder.sv
// Byte-command responder behind a UART: ping, register read and register write, each answered with one byte.
// Optional inter-byte timeout in GET_ADDR/GET_DATA is enabled by defining UART_RESP_TIMEOUT_EN.
module uart_link_responder #(
    parameter int NREG           = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 give_clk,
    input  logic                 give_reset,
    uart_link_responder_if.slave bus,
    output logic [8*NREG-1:0]    reg_out,
    output logic [NREG-1:0]      reg_wr
);
    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;
    localparam int         ADDR_W    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0] NREG_BYTE = 8'(NREG);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              valid_prev;
    logic              perr_prev;
    logic              ferr_prev;
    logic              byte_rise;
    logic              err_rise;
    logic              is_write;
    logic              is_write_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] rx_addr;
    logic [7:0]        resp;
    logic [7:0]        resp_next;
    logic              reg_load;
    logic              tx_load;
    logic              tx_strobe;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic [7:0]        regs [NREG];

    assign byte_rise = bus.Rx_VALID & ~valid_prev;
    assign err_rise  = (bus.Rx_PERROR & ~perr_prev) | (bus.Rx_FERROR & ~ferr_prev);
    assign rx_addr   = bus.Rx_DATA[ADDR_W-1:0];

`ifdef UART_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_count;
    logic          timeout_hit;

    // Counts clocks spent waiting for an operand byte; any accepted byte or error edge restarts it.
    always_ff @(posedge give_clk) begin
        if (give_reset) begin
            idle_count <= '0;
        end else if ((state == GET_ADDR || state == GET_DATA) && !byte_rise && !err_rise && !timeout_hit) begin
            idle_count <= idle_count + 1'b1;
        end else begin
            idle_count <= '0;
        end
    end

    assign timeout_hit = (idle_count == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge give_clk) begin
        if (give_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        is_write_next = is_write;
        addr_next     = addr;
        resp_next     = resp;
        reg_load      = 1'b0;
        tx_load       = 1'b0;
        tx_strobe     = 1'b0;
        unique case (state)
            IDLE: begin
                if (err_rise) begin
                    resp_next  = NAK;
                    state_next = EXEC;
                end else if (byte_rise) begin
                    case (bus.Rx_DATA)
                        CMD_PING: begin
                            resp_next  = ACK;
                            state_next = EXEC;
                        end
                        CMD_READ, CMD_WRITE: begin
                            is_write_next = (bus.Rx_DATA == CMD_WRITE);
                            state_next    = GET_ADDR;
                        end
                        default: begin
                            resp_next  = NAK;
                            state_next = EXEC;
                        end
                    endcase
                end
            end
            GET_ADDR: begin
                if (err_rise) begin
                    resp_next  = NAK;
                    state_next = EXEC;
                end else if (byte_rise) begin
                    if (bus.Rx_DATA >= NREG_BYTE) begin
                        resp_next  = NAK;
                        state_next = EXEC;
                    end else if (is_write) begin
                        addr_next  = rx_addr;
                        state_next = GET_DATA;
                    end else begin
                        resp_next  = regs[rx_addr];
                        state_next = EXEC;
                    end
                end
`ifdef UART_RESP_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = IDLE;
                end
`endif
            end
            GET_DATA: begin
                if (err_rise) begin
                    resp_next  = NAK;
                    state_next = EXEC;
                end else if (byte_rise) begin
                    reg_load   = 1'b1;
                    resp_next  = ACK;
                    state_next = EXEC;
                end
`ifdef UART_RESP_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = IDLE;
                end
`endif
            end
            EXEC: begin
                tx_load    = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (!bus.TX_BUSY) begin
                    tx_strobe  = 1'b1;
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.TX_BUSY) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.TX_BUSY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Edge history keeps tracking in every state so a level held through a response is never re-accepted.
    always_ff @(posedge give_clk) begin
        if (give_reset) begin
            valid_prev <= 1'b0;
            perr_prev  <= 1'b0;
            ferr_prev  <= 1'b0;
            is_write   <= 1'b0;
            addr       <= '0;
            resp       <= '0;
            tx_data    <= '0;
            tx_wr      <= 1'b0;
            reg_wr     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            valid_prev <= bus.Rx_VALID;
            perr_prev  <= bus.Rx_PERROR;
            ferr_prev  <= bus.Rx_FERROR;
            is_write   <= is_write_next;
            addr       <= addr_next;
            resp       <= resp_next;
            tx_wr      <= tx_strobe;
            reg_wr     <= '0;
            if (tx_load) begin
                tx_data <= resp;
            end
            if (reg_load) begin
                regs[addr] <= bus.Rx_DATA;
                reg_wr     <= NREG'(1) << addr;
            end
        end
    end

    assign bus.Tx_DATA = tx_data;
    assign bus.Tx_WR   = tx_wr;

    for (genvar g = 0; g < NREG; g++) begin : g_reg_out
        assign reg_out[8*g +: 8] = regs[g];
    end
endmodule

// File: tb/tb_uart_link_responder.sv
// Directed bench for uart_link_responder: a command-level model predicts register contents and response bytes,
// a per-cycle compare process checks the DUT against it, and literal expectations pin the model.
module tb_uart_link_responder;
    localparam int         NREG = 4;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic              give_clk = 1'b0;
    logic              give_reset;
    logic [8*NREG-1:0] reg_out;
    logic [NREG-1:0]   reg_wr;
    logic              hold_busy;
    logic              emul_busy;
    logic              emul_en;
    logic              chk_en;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [7:0]        model_regs [NREG];
    logic [7:0]        exp_tx [$];
    logic [NREG-1:0]   exp_reg_wr;
    logic [NREG-1:0]   seen_reg_wr;
    logic [8*NREG-1:0] model_flat;
    logic [7:0]        got_data;
    int                got_lat;

    uart_link_responder_if bus ();

    assign bus.TX_BUSY = hold_busy | emul_busy;

    uart_link_responder #(
        .NREG           (NREG),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .give_clk   (give_clk),
        .give_reset (give_reset),
        .bus        (bus),
        .reg_out    (reg_out),
        .reg_wr     (reg_wr)
    );

    always #5 give_clk = ~give_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model versus DUT on every falling edge: registers, write pulses and each transmitted byte.
    always @(negedge give_clk) begin
        if (chk_en) begin
            for (int i = 0; i < NREG; i++) model_flat[8*i +: 8] = model_regs[i];
            checkOutput("reg_out", reg_out, model_flat);
            checkOutput("reg_wr", reg_wr, exp_reg_wr);
            if (reg_wr != '0) seen_reg_wr = reg_wr;
            exp_reg_wr = '0;
            if (bus.Tx_WR === 1'b1) begin
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL tx_wr_unexpected: got Tx_WR=1 with Tx_DATA=0x%0h, expected no write", bus.Tx_DATA);
                end else begin
                    checkOutput("tx_data", bus.Tx_DATA, exp_tx.pop_front());
                end
            end else begin
                checkOutput("tx_wr_level", bus.Tx_WR, 1'b0);
            end
        end
    end

    // Transmitter stand-in: goes busy the clock after each write strobe and stays busy for five clocks.
    initial begin
        emul_busy = 1'b0;
        forever begin
            @(negedge give_clk);
            if (emul_en && bus.Tx_WR === 1'b1) begin
                @(posedge give_clk);
                #1 emul_busy = 1'b1;
                repeat (5) @(posedge give_clk);
                #1 emul_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic gap(input int n);
        repeat (n) @(posedge give_clk);
        #1;
    endtask

    // Presents one byte with a single-clock valid pulse; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.Rx_DATA  = b;
        bus.Rx_VALID = 1'b1;
        @(posedge give_clk);
        #1;
        bus.Rx_VALID = 1'b0;
    endtask

    task automatic waitTx(output logic [7:0] data, output int lat);
        lat  = -1;
        data = 8'h00;
        for (int c = 0; c < 60; c++) begin
            @(negedge give_clk);
            if (bus.Tx_WR === 1'b1) begin
                data = bus.Tx_DATA;
                lat  = c;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL tx_timeout: got no Tx_WR within 60 clocks, expected one");
        end
        @(posedge give_clk);
        #1;
    endtask

    task automatic finishCommand(input string name, input logic [7:0] lit);
        waitTx(got_data, got_lat);
        checkOutput({name, "_latency"}, got_lat, 2);
        checkOutput({name, "_byte"}, got_data, lit);
        gap(12);
    endtask

    task automatic doSingle(input logic [7:0] b, input logic [7:0] lit, input string name);
        applyStimulus(b);
        exp_tx.push_back((b == 8'h50) ? ACK : NAK);
        finishCommand(name, lit);
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [7:0] d, input logic [7:0] lit, input string name);
        applyStimulus(8'h57);
        gap(1);
        applyStimulus(a);
        if (a < NREG) begin
            gap(1);
            applyStimulus(d);
            model_regs[a] = d;
            exp_reg_wr    = NREG'(1) << a;
            exp_tx.push_back(ACK);
        end else begin
            exp_tx.push_back(NAK);
        end
        finishCommand(name, lit);
    endtask

    task automatic doRead(input logic [7:0] a, input logic [7:0] lit, input string name);
        applyStimulus(8'h52);
        gap(1);
        applyStimulus(a);
        exp_tx.push_back((a < NREG) ? model_regs[a] : NAK);
        finishCommand(name, lit);
    endtask

    initial begin
        give_reset    = 1'b1;
        bus.Rx_DATA   = 8'h00;
        bus.Rx_VALID  = 1'b0;
        bus.Rx_PERROR = 1'b0;
        bus.Rx_FERROR = 1'b0;
        hold_busy     = 1'b0;
        emul_en       = 1'b1;
        chk_en        = 1'b0;
        exp_reg_wr    = '0;
        seen_reg_wr   = '0;
        for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;

        repeat (3) @(posedge give_clk);
        #1;
        give_reset = 1'b0;
        chk_en     = 1'b1;
        @(negedge give_clk);
        checkOutput("reset_tx_wr", bus.Tx_WR, 1'b0);
        checkOutput("reset_tx_data", bus.Tx_DATA, 8'h00);
        checkOutput("reset_reg_wr", reg_wr, 4'b0000);
        checkOutput("reset_reg_out", reg_out, 32'h0000_0000);
        gap(1);

        doWrite(8'h02, 8'hA5, 8'h06, "wr2");
        checkOutput("wr2_reg_wr_onehot", seen_reg_wr, 4'b0100);
        checkOutput("wr2_reg2_value", reg_out[23:16], 8'hA5);
        doRead(8'h02, 8'hA5, "rd2");
        doRead(8'h07, 8'h15, "rd_bad_addr");
        checkOutput("rd_bad_regs_kept", reg_out, 32'h00A5_0000);
        doSingle(8'h33, 8'h15, "bad_cmd");
        doSingle(8'h50, 8'h06, "ping");

        doWrite(8'h00, 8'h3C, 8'h06, "wr0");
        doWrite(8'h03, 8'hC3, 8'h06, "wr3");
        doWrite(8'h01, 8'h5A, 8'h06, "wr1");
        doWrite(8'h09, 8'hFF, 8'h15, "wr_bad_addr");
        checkOutput("regs_isolated", reg_out, 32'hC3A5_5A3C);
        doRead(8'h00, 8'h3C, "rd0");
        doRead(8'h03, 8'hC3, "rd3");

        // Valid level held for 50 clocks must produce a single response.
        bus.Rx_DATA  = 8'h50;
        bus.Rx_VALID = 1'b1;
        @(posedge give_clk);
        #1;
        exp_tx.push_back(ACK);
        waitTx(got_data, got_lat);
        checkOutput("held_valid_latency", got_lat, 2);
        checkOutput("held_valid_byte", got_data, 8'h06);
        gap(45);
        bus.Rx_VALID = 1'b0;
        gap(15);

        // Transmitter busy for 20 clocks; a byte arriving meanwhile must be ignored.
        hold_busy = 1'b1;
        applyStimulus(8'h50);
        exp_tx.push_back(ACK);
        for (int c = 0; c < 8; c++) begin
            @(negedge give_clk);
            checkOutput("busy_no_early_wr", bus.Tx_WR, 1'b0);
        end
        gap(1);
        applyStimulus(8'h52);
        for (int c = 0; c < 10; c++) begin
            @(negedge give_clk);
            checkOutput("busy_no_early_wr", bus.Tx_WR, 1'b0);
        end
        @(posedge give_clk);
        #1;
        hold_busy = 1'b0;
        waitTx(got_data, got_lat);
        checkOutput("busy_release_latency", got_lat, 1);
        checkOutput("busy_release_byte", got_data, 8'h06);
        gap(12);
        doSingle(8'h50, 8'h06, "after_discard_ping");

        // Parity error edge while waiting for write data.
        applyStimulus(8'h57);
        gap(1);
        applyStimulus(8'h01);
        gap(1);
        bus.Rx_PERROR = 1'b1;
        @(posedge give_clk);
        #1;
        bus.Rx_PERROR = 1'b0;
        exp_tx.push_back(NAK);
        finishCommand("perr_get_data", 8'h15);
        checkOutput("perr_reg1_kept", reg_out[15:8], 8'h5A);

        // Framing error edge while waiting for an address.
        applyStimulus(8'h52);
        gap(1);
        bus.Rx_FERROR = 1'b1;
        @(posedge give_clk);
        #1;
        bus.Rx_FERROR = 1'b0;
        exp_tx.push_back(NAK);
        finishCommand("ferr_get_addr", 8'h15);

        // Reset while parked in WAIT_HI: transmitter never goes busy.
        emul_en = 1'b0;
        applyStimulus(8'h50);
        exp_tx.push_back(ACK);
        waitTx(got_data, got_lat);
        checkOutput("pre_reset_byte", got_data, 8'h06);
        gap(5);
        give_reset = 1'b1;
        @(posedge give_clk);
        #1;
        give_reset = 1'b0;
        for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
        exp_tx.delete();
        emul_en = 1'b1;
        gap(20);
        checkOutput("post_reset_regs", reg_out, 32'h0000_0000);
        checkOutput("post_reset_tx_data", bus.Tx_DATA, 8'h00);
        doSingle(8'h50, 8'h06, "post_reset_ping");

`ifdef UART_RESP_TIMEOUT_EN
        applyStimulus(8'h57);
        gap(105);
        doSingle(8'h50, 8'h06, "timeout_ping");
`endif

        checkOutput("tx_queue_drained", exp_tx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_link_responder.md
UART_LINK_RESPONDER -- requirements
Module: uart_link_responder

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter NREG, default 4, SHALL set the number of 8-bit registers (1..16).
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, SHALL set the inter-byte timeout in clocks (used only under REQ-025).
REQ-004 Port give_clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port give_reset  input  1  synchronous active-high reset.
REQ-006 Port Rx_DATA  input  8  received byte from the UART receiver.
REQ-007 Port Rx_VALID  input  1  receiver byte-valid level; may stay high for many clocks.
REQ-008 Port Rx_PERROR, Rx_FERROR  input  1 each  receiver parity and framing error levels.
REQ-009 Port TX_BUSY  input  1  UART transmitter busy level.
REQ-010 Port Tx_DATA  output  8  response byte to the UART transmitter.
REQ-011 Port Tx_WR  output  1  one-clock write strobe to the transmitter.
REQ-012 Port reg_out  output  8*NREG  register contents; register i occupies bits [8i+7:8i].
REQ-013 Port reg_wr  output  NREG  one-hot, one-clock pulse marking the register written.

Function
REQ-014 A received byte SHALL be accepted only on a rising edge of Rx_VALID (0 on the previous clock, 1 on the current clock); a level held high SHALL NOT be accepted again.
REQ-015 A rising edge of Rx_PERROR or Rx_FERROR in any receive state SHALL abort the current command and queue NAK 0x15.
REQ-016 The state machine SHALL have these states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_HI, WAIT_LO.
REQ-017 Command bytes in IDLE SHALL be handled as follows:
- 0x50 ('P', ping): goes to EXEC with response ACK 0x06.
- 0x52 ('R') and 0x57 ('W'): go to GET_ADDR.
- Any other byte: goes to EXEC with response NAK 0x15.
REQ-018 In GET_ADDR, an address byte of NREG or greater SHALL produce NAK.
- Valid address after 'R': goes to EXEC with response equal to the register value.
- Valid address after 'W': goes to GET_DATA.
REQ-019 In GET_DATA, the accepted byte SHALL be written to the addressed register, and the matching reg_wr bit SHALL pulse in the same clock the register updates. The response SHALL be ACK 0x06.
REQ-020 EXEC SHALL last one clock.
- SEND is entered next, and Tx_DATA is loaded there.
- In SEND, Tx_WR SHALL pulse for exactly one clock in the first clock where TX_BUSY=0. The state then goes to WAIT_HI.
- Latency: Tx_WR goes high 2 clocks after the accepting edge when TX_BUSY is low.
REQ-021 WAIT_HI SHALL wait for TX_BUSY=1, then WAIT_LO SHALL wait for TX_BUSY=0, then the state returns to IDLE. Tx_DATA SHALL stay stable from Tx_WR until the return to IDLE.
REQ-022 Bytes and error edges arriving in EXEC, SEND, WAIT_HI or WAIT_LO SHALL be discarded without changing any state.
REQ-023 Register writes SHALL affect only the addressed register. A read of an address written in the same command sequence SHALL return the new value.

Reset
REQ-024 While give_reset=1, on each clock the block SHALL:
- go to state IDLE;
- drive Tx_WR=0, Tx_DATA=0x00, reg_wr=0;
- clear all registers to 0x00;
- clear the edge-detect history to 0.
This applies mid-command or mid-send, with no response byte emitted afterwards.

Configuration
REQ-025 With macro UART_RESP_TIMEOUT_EN defined:
- A counter SHALL run in GET_ADDR and GET_DATA and reset on each accepted byte.
- When it reaches TIMEOUT_CYCLES, the block SHALL abort to IDLE with no response.
Without the macro, GET_ADDR and GET_DATA SHALL wait indefinitely, and the counter SHALL NOT exist.

Verification
REQ-026 Bytes 0x57, 0x02, 0xA5 -> reg_wr=0b0100 for one clock, register 2 = 0xA5, one Tx_WR with Tx_DATA=0x06.
REQ-027 Bytes 0x52, 0x02 after REQ-026 -> one Tx_WR with Tx_DATA=0xA5, 2 clocks after the address edge with TX_BUSY=0.
REQ-028 Byte 0x52 then address 0x07 (NREG=4) -> Tx_DATA=0x15, no register change; byte 0x33 in IDLE -> Tx_DATA=0x15.
REQ-029 Rx_VALID held high 50 clocks with 0x50 -> exactly one Tx_WR with 0x06. TX_BUSY held 1 for 20 clocks -> Tx_WR is delayed until TX_BUSY=0.
REQ-030 Rx_PERROR rising edge in GET_DATA -> NAK 0x15 and registers unchanged. give_reset pulsed during WAIT_HI -> IDLE, all registers 0x00, no further Tx_WR.
REQ-031 With UART_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=100: byte 0x57, then 100 idle clocks -> state IDLE, no Tx_WR. Then byte 0x50 -> ACK 0x06.
